card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/poker_pkg.sv | 45 ++++
 rtl/card_lfsr.sv | 39 +++
 rtl/card_dealer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/poker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poker_pkg
// Description : Shared constants, LFSR taps, card helpers and dealer state
//               encoding for the video-poker card dealer.
// Revision    : 1.0 - initial release
// ============================================================================
package poker_pkg;

  // Card code is {suit[1:0], rank[3:0]}
  localparam int CARD_W    = 6;
  localparam int NUM_SLOTS = 5;
  localparam int RANK_MIN  = 1;
  localparam int RANK_MAX  = 13;

  // 16-bit Fibonacci LFSR, shifting left, feedback from these bit positions
  localparam int          LFSR_W     = 16;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          LFSR_TAP_A = 15;
  localparam int          LFSR_TAP_B = 13;
  localparam int          LFSR_TAP_C = 12;
  localparam int          LFSR_TAP_D = 10;

  // Dealer controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } dealer_state_t;

  // Operation latched when a request is accepted
  typedef enum logic [1:0] {
    OP_DEAL = 2'd0,
    OP_DRAW = 2'd1,
    OP_DUP  = 2'd2
  } dealer_op_t;

  // True when a rank nibble names a real card (ace..king)
  function automatic logic rank_ok(input logic [3:0] rank);
    return (rank >= 4'(RANK_MIN)) && (rank <= 4'(RANK_MAX));
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : card_lfsr
// Description : Free-running 16-bit Fibonacci LFSR used as the shuffle source.
//               Advances every cycle; a load replaces the state with the seed
//               (an all-zero seed is substituted, since zero would lock up).
// Revision    : 1.0 - initial release
// ============================================================================
module card_lfsr
  import poker_pkg::*;
(
  input  logic              clock,
  input  logic              reset_c,
  input  logic              ld,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;
  logic [LFSR_W-1:0] w_seed_safe;

  assign w_fb        = r_q[LFSR_TAP_A] ^ r_q[LFSR_TAP_B] ^ r_q[LFSR_TAP_C] ^ r_q[LFSR_TAP_D];
  assign w_seed_safe = (seed == '0) ? LFSR_SEED : seed;
  assign q           = r_q;

  // Shift register: reset to the default seed, load on request, else advance
  always_ff @(posedge clock) begin
    if (!reset_c) begin
      r_q <= LFSR_SEED;
    end else if (ld) begin
      r_q <= w_seed_safe;
    end else begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// Module      : card_dealer
// Description : Deals a 5-card poker hand, redraws non-held cards and deals a
//               single double-up card. Candidates come from the low six LFSR
//               bits; a 64-bit used mask guarantees no card repeats within a
//               hand (discards stay marked until the next fresh deck).
// Revision    : 1.0 - initial release
// ============================================================================
module card_dealer
  import poker_pkg::*;
(
  input  logic              clock,
  input  logic              reset_c,
  input  logic              deal_req,
  input  logic              draw_req,
  input  logic              dup_req,
  input  logic [4:0]        hold,
  input  logic              seed_ld,
  input  logic [15:0]       seed,
  output logic [CARD_W-1:0] card0,
  output logic [CARD_W-1:0] card1,
  output logic [CARD_W-1:0] card2,
  output logic [CARD_W-1:0] card3,
  output logic [CARD_W-1:0] card4,
  output logic [CARD_W-1:0] dup_card,
  output logic              busy,
  output logic              done
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  dealer_state_t      r_state;
  dealer_state_t      w_state_nxt;
  dealer_op_t         r_op;
  logic [2:0]         r_slot;
  logic [4:0]         r_hold;
  logic [63:0]        r_used;
  logic [CARD_W-1:0]  r_card [NUM_SLOTS];
  logic [CARD_W-1:0]  r_dup;

  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_lfsr_unused;
  logic               w_seed_ld;
  logic [CARD_W-1:0]  w_cand;
  logic               w_cand_ok;
  logic               w_skip;
  logic               w_commit;
  logic               w_advance;
  logic               w_last;

  // --------------------------------------------------------------------------
  // Random source; seeding is only honoured while idle
  // --------------------------------------------------------------------------
  assign w_seed_ld = seed_ld && (r_state == ST_IDLE);

  card_lfsr u_lfsr (
    .clock   (clock),
    .reset_c (reset_c),
    .ld      (w_seed_ld),
    .seed    (seed),
    .q       (w_lfsr)
  );

  // Only the low six bits form a card; the rest only feed the LFSR itself
  assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:CARD_W];

  // --------------------------------------------------------------------------
  // Slot resolution in SCAN
  // --------------------------------------------------------------------------
  assign w_cand    = w_lfsr[CARD_W-1:0];
  assign w_cand_ok = rank_ok(w_cand[3:0]) && !r_used[w_cand];
  // Held slots are skipped only when redrawing
  assign w_skip    = (r_op == OP_DRAW) && r_hold[r_slot];
  assign w_commit  = (r_state == ST_SCAN) && !w_skip && w_cand_ok;
  assign w_advance = (r_state == ST_SCAN) && (w_skip || w_cand_ok);
  // Double-up needs one card; hands finish once the final slot resolves
  assign w_last    = (r_op == OP_DUP) || (r_slot == 3'(NUM_SLOTS - 1));

  // --------------------------------------------------------------------------
  // Controller state register
  // --------------------------------------------------------------------------
  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_c) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; requests only count while idle
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (deal_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (draw_req) begin
          w_state_nxt = ST_SCAN;
        end else if (dup_req) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_advance && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operation latch, slot pointer, used mask and card registers
  // --------------------------------------------------------------------------
  // Latch the accepted operation and hold mask, walk slots, commit cards
  always_ff @(posedge clock) begin
    if (!reset_c) begin
      r_op   <= OP_DEAL;
      r_slot <= 3'd0;
      r_hold <= 5'd0;
      r_used <= 64'd0;
      r_dup  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_card[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_slot <= 3'd0;
          if (deal_req) begin
            r_op <= OP_DEAL;
          end else if (draw_req) begin
            // A redraw keeps the used mask so discards never come back
            r_op   <= OP_DRAW;
            r_hold <= hold;
          end else if (dup_req) begin
            r_op <= OP_DUP;
          end
        end
        ST_CLEAR: begin
          // Fresh deck for deal and double-up
          r_used <= 64'd0;
          r_slot <= 3'd0;
        end
        ST_SCAN: begin
          if (w_advance) begin
            r_slot <= r_slot + 3'd1;
          end
          if (w_commit) begin
            r_used[w_cand] <= 1'b1;
            if (r_op == OP_DUP) begin
              r_dup <= w_cand;
            end
          end
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_commit && (r_op != OP_DUP) && (r_slot == 3'(i))) begin
              r_card[i] <= w_cand;
            end
          end
        end
        default: begin
          r_slot <= r_slot;
        end
      endcase
    end
  end

  assign card0    = r_card[0];
  assign card1    = r_card[1];
  assign card2    = r_card[2];
  assign card3    = r_card[3];
  assign card4    = r_card[4];
  assign dup_card = r_dup;

endmodule
`default_nettype wire
